tile_loader: RTL and testbench

- Upstream feeder for the VGA tile renderer: receives tile bitmap rows from an external host over a byte-wide, asynchronously strobed port.
- Assembles each 64-bit row (32 pixels × 2-bit colour) and commits it to the renderer's tile memory through a one-cycle write port.
- Commits only during vertical blank, so a frame never shows a half-updated tile.

---
 rtl/nyan_pkg.sv | 26 ++
 rtl/sync_edge.sv | 31 +++
 rtl/tile_loader.sv | 119 +++++++++++
 tb/tb_tile_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nyan_pkg.sv
// rtl/nyan_pkg.sv - shared constants, VGA timing and loader FSM states for the tile path
package nyan_pkg;

  localparam int ROWS     = 32;
  localparam int ROW_BITS = 64;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int HDR_CLR_ERR = 7;
  localparam int HDR_ROW_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2,
    S_PEND = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser for a strobed bus plus strobe rising-edge pulse
module sync_edge #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         strb,
  output logic [W-1:0] q,
  output logic         evt
);

  // Strobe and data share one chain so they stay aligned at the last stage.
  logic [STAGES-1:0][W:0] chain;
  logic                   strb_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain    <= '0;
      strb_dly <= 1'b0;
    end else begin
      chain    <= {chain[STAGES-2:0], {strb, d}};
      strb_dly <= chain[STAGES-1][W];
    end
  end

  assign q   = chain[STAGES-1][W-1:0];
  assign evt = chain[STAGES-1][W] & ~strb_dly;

endmodule

// File: rtl/tile_loader.sv
// rtl/tile_loader.sv - host byte port to tile-row writer, commits during vblank
// Optional trailing XOR checksum byte per row: TILE_LOADER_CHECKSUM_EN.
module tile_loader #(
  parameter int ROWS        = nyan_pkg::ROWS,
  parameter int ROW_BITS    = nyan_pkg::ROW_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              din,
  input  logic                    din_cmd,
  input  logic                    din_strb,
  input  logic                    vblank,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic [ROW_BITS-1:0]     wr_data,
  output logic                    busy,
  output logic                    err
);
  import nyan_pkg::*;

  localparam int BYTES = ROW_BITS / 8;
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  logic             evt;
  logic [8:0]       cap;
  logic             hdr_evt;
  logic             dat_evt;
  logic [7:0]       byte_q;
  logic             hdr_clr;
  logic [ROW_W-1:0] hdr_row;
  state_e           state;
  logic [CNT_W-1:0] cnt;
`ifdef TILE_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  sync_edge #(
    .W      (9),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({din_cmd, din}),
    .strb  (din_strb),
    .q     (cap),
    .evt   (evt)
  );

  assign byte_q  = cap[7:0];
  assign hdr_evt = evt & cap[8];
  assign dat_evt = evt & ~cap[8];
  assign hdr_clr = byte_q[HDR_CLR_ERR];
  assign hdr_row = byte_q[HDR_ROW_LSB +: ROW_W];

  assign busy  = (state == S_PEND);
  assign wr_en = busy & vblank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_row  <= '0;
      wr_data <= '0;
      err     <= 1'b0;
`ifdef TILE_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else if (hdr_evt && !busy) begin
      // A header mid-row aborts it; the clear bit still wins over the abort error.
      wr_row <= hdr_row;
      cnt    <= '0;
      state  <= S_DATA;
`ifdef TILE_LOADER_CHECKSUM_EN
      csum   <= '0;
`endif
      if (state != S_IDLE) err <= ~hdr_clr;
      else if (hdr_clr)    err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dat_evt) err <= 1'b1;
        end
        S_DATA: begin
          if (dat_evt) begin
            wr_data <= (wr_data << 8) | ROW_BITS'(byte_q);
            cnt     <= cnt + CNT_W'(1);
`ifdef TILE_LOADER_CHECKSUM_EN
            csum    <= csum ^ byte_q;
            if (cnt == LAST_BYTE) state <= S_CSUM;
`else
            if (cnt == LAST_BYTE) state <= S_PEND;
`endif
          end
        end
`ifdef TILE_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (dat_evt) begin
            if (byte_q == csum) begin
              state <= S_PEND;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_PEND: begin
          if (evt)    err   <= 1'b1;
          if (vblank) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_loader.sv
// tb/tb_tile_loader.sv - table-driven check of tile_loader row assembly, gating and errors
module tb_tile_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_cmd = 1'b0;
  logic        din_strb = 1'b0;
  logic        vblank = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [63:0] wr_data;
  logic        busy;
  logic        err;

  tile_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_cmd  (din_cmd),
    .din_strb (din_strb),
    .vblank   (vblank),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          busy_cnt = 0;
  int          cap_cyc = 0;
  int          last_rise = 0;
  logic [4:0]  cap_row = '0;
  logic [63:0] cap_data = '0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt   = wr_cnt + 1;
        cap_row  = wr_row;
        cap_data = wr_data;
        cap_cyc  = cyc;
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  typedef struct {
    logic        has_hdr;
    logic [7:0]  hdr;
    int          nbytes;
    logic [63:0] data;
    logic        vb;
    logic        exp_wr;
    logic [4:0]  exp_row;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic cmd, input logic [7:0] b);
    din     = b;
    din_cmd = cmd;
    tick(1);
    din_strb  = 1'b1;
    last_rise = cyc;
    tick(3);
    din_strb = 1'b0;
    tick(3);
  endtask

  task automatic send_row(input logic [63:0] d, input int n);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = d[63-8*i -: 8];
      x = x ^ b;
      send(1'b0, b);
    end
`ifdef TILE_LOADER_CHECKSUM_EN
    if (n == 8) send(1'b0, x);
`endif
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   raise;
    tbl[0] = '{1'b1, 8'h05, 8, 64'h1122334455667788, 1'b1, 1'b1, 5'd5,  64'h1122334455667788, 1'b0};
    tbl[1] = '{1'b1, 8'h1F, 8, 64'hDEADBEEF01234567, 1'b1, 1'b1, 5'd31, 64'hDEADBEEF01234567, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1, 64'hAA00000000000000, 1'b1, 1'b0, 5'd0,  64'h0,                1'b1};
    tbl[3] = '{1'b1, 8'h80, 8, 64'h0102030405060708, 1'b1, 1'b1, 5'd0,  64'h0102030405060708, 1'b0};
    tbl[4] = '{1'b1, 8'h23, 8, 64'hF0E0D0C0B0A09080, 1'b1, 1'b1, 5'd3,  64'hF0E0D0C0B0A09080, 1'b0};
    tbl[5] = '{1'b1, 8'h07, 4, 64'hA1A2A3A400000000, 1'b1, 1'b0, 5'd0,  64'h0,                1'b0};
    tbl[6] = '{1'b1, 8'h03, 8, 64'h0F1E2D3C4B5A6978, 1'b1, 1'b1, 5'd3,  64'h0F1E2D3C4B5A6978, 1'b1};
    tbl[7] = '{1'b1, 8'h01, 2, 64'h1234000000000000, 1'b1, 1'b0, 5'd0,  64'h0,                1'b1};
    tbl[8] = '{1'b1, 8'h80, 8, 64'h8877665544332211, 1'b1, 1'b1, 5'd0,  64'h8877665544332211, 1'b0};

    // Reset held while the host keeps strobing headers.
    rst_n   = 1'b0;
    vblank  = 1'b1;
    din     = 8'hFF;
    din_cmd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_strb = 1'b1;
      tick(4);
      din_strb = 1'b0;
      tick(4);
    end
    chk("rst_wr_en",   64'(wr_en),   64'h0);
    chk("rst_wr_row",  64'(wr_row),  64'h0);
    chk("rst_wr_data", wr_data,      64'h0);
    chk("rst_busy",    64'(busy),    64'h0);
    chk("rst_err",     64'(err),     64'h0);
    rst_n  = 1'b1;
    wr_cnt = 0;
    tick(20);
    chk("idle_no_write", 64'(wr_cnt), 64'h0);

    for (int i = 0; i < 9; i++) begin
      wr_cnt   = 0;
      busy_cnt = 0;
      vblank   = tbl[i].vb;
      if (tbl[i].has_hdr) send(1'b1, tbl[i].hdr);
      send_row(tbl[i].data, tbl[i].nbytes);
      tick(4);
      chk($sformatf("v%0d_writes", i), 64'(wr_cnt), 64'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) begin
        chk($sformatf("v%0d_row", i),  64'(cap_row), 64'(tbl[i].exp_row));
        chk($sformatf("v%0d_data", i), cap_data,     tbl[i].exp_data);
        if (tbl[i].vb) begin
          chk($sformatf("v%0d_latency", i),   64'(cap_cyc - last_rise), 64'd3);
          chk($sformatf("v%0d_busy_cyc", i), 64'(busy_cnt),            64'd1);
        end
      end
      chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
    end

    // Commit held off until vblank; a strobe while busy is rejected.
    vblank   = 1'b0;
    wr_cnt   = 0;
    send(1'b1, 8'h09);
    send_row(64'h0011223344556677, 8);
    tick(100);
    chk("gate_busy",     64'(busy),   64'h1);
    chk("gate_no_write", 64'(wr_cnt), 64'h0);
    send(1'b0, 8'h55);
    tick(2);
    chk("gate_strobe_err",   64'(err),    64'h1);
    chk("gate_strobe_nowr",  64'(wr_cnt), 64'h0);
    vblank = 1'b1;
    raise  = cyc;
    #1;
    chk("gate_wr_en_now", 64'(wr_en), 64'h1);
    tick(2);
    chk("gate_writes",  64'(wr_cnt),        64'h1);
    chk("gate_row",     64'(cap_row),       64'd9);
    chk("gate_data",    cap_data,           64'h0011223344556677);
    chk("gate_cycle",   64'(cap_cyc - raise), 64'h0);
    chk("gate_idle",    64'(busy),          64'h0);

    // Reset mid-row discards the partial row.
    wr_cnt = 0;
    send(1'b1, 8'h0A);
    send_row(64'h0102030405000000, 5);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("midrst_no_write", 64'(wr_cnt), 64'h0);
    chk("midrst_busy",     64'(busy),   64'h0);
    chk("midrst_err",      64'(err),    64'h0);
    wr_cnt = 0;
    send(1'b1, 8'h1F);
    send_row(64'hCAFEF00DBAADC0DE, 8);
    tick(4);
    chk("post_rst_writes", 64'(wr_cnt),  64'h1);
    chk("post_rst_row",    64'(cap_row), 64'd31);
    chk("post_rst_data",   cap_data,     64'hCAFEF00DBAADC0DE);

`ifdef TILE_LOADER_CHECKSUM_EN
    wr_cnt = 0;
    send(1'b1, 8'h02);
    for (int i = 0; i < 8; i++) send(1'b0, 8'hFF);
    send(1'b0, 8'h00);
    tick(4);
    chk("csum_ok_writes", 64'(wr_cnt),  64'h1);
    chk("csum_ok_row",    64'(cap_row), 64'd2);
    chk("csum_ok_err",    64'(err),     64'h0);
    wr_cnt = 0;
    send(1'b1, 8'h02);
    for (int i = 0; i < 8; i++) send(1'b0, 8'hFF);
    send(1'b0, 8'h01);
    tick(4);
    chk("csum_bad_writes", 64'(wr_cnt), 64'h0);
    chk("csum_bad_err",    64'(err),    64'h1);
    chk("csum_bad_busy",   64'(busy),   64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
